// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared CPU constants: opcodes, ALU control, M-extension codes and muldiv FSM states
package muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Major opcodes used by the integer pipeline
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU control encoding
  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_ctrl_e;

  // RV32M funct3 codes
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // rs1 is treated as two's complement
  function automatic logic op_a_signed(md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic op_b_signed(md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit with fixed latency
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  md_op_e          op_q, op_d;
  logic            a_neg_q, a_neg_d;
  logic            b_neg_q, b_neg_d;
  logic            div0_q, div0_d;
  // hi: partial product / partial remainder; lo: multiplier / dividend-then-quotient
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] bmag_q, bmag_d;
  logic [XLEN-1:0] result_q, result_d;

  md_op_e          op_in;
  logic            a_in_neg, b_in_neg;
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shl_rem;
  logic [XLEN:0]   sub_diff;
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  // Operand decode, one iteration step and the sign-correction network
  always_comb begin
    op_in    = md_op_e'(op_i);
    a_in_neg = op_a_signed(op_in) & a_i[XLEN-1];
    b_in_neg = op_b_signed(op_in) & b_i[XLEN-1];

    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);
    shl_rem  = {hi_q, lo_q[XLEN-1]};
    sub_diff = shl_rem - {1'b0, bmag_q};

    prod_raw = {hi_q, lo_q};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod_raw : prod_raw;
    // Divide-by-zero keeps the all-ones quotient regardless of the dividend sign
    quot_fix = ((a_neg_q ^ b_neg_q) && !div0_q) ? -lo_q : lo_q;
    rem_fix  = a_neg_q ? -hi_q : hi_q;

    fix_result = '0;
    case (op_q)
      MD_MUL:                       fix_result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_result = quot_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bmag_d   = bmag_q;
    result_d = result_q;

    if (kill_i) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_CALC;
            cnt_d   = '0;
            op_d    = op_in;
            a_neg_d = a_in_neg;
            b_neg_d = b_in_neg;
            div0_d  = (b_i == '0);
            hi_d    = '0;
            lo_d    = a_in_neg ? -a_i : a_i;
            bmag_d  = b_in_neg ? -b_i : b_i;
          end
        end
        ST_CALC: begin
          if (op_q[2]) begin
            // Restoring division: keep the trial difference only when it did not borrow
            if (!sub_diff[XLEN]) begin
              hi_d = sub_diff[XLEN-1:0];
            end else begin
              hi_d = shl_rem[XLEN-1:0];
            end
            lo_d = {lo_q[XLEN-2:0], ~sub_diff[XLEN]};
          end else begin
            hi_d = add_sum[XLEN:1];
            lo_d = {add_sum[0], lo_q[XLEN-1:1]};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
            cnt_d   = '0;
          end
        end
        ST_FIX: begin
          result_d = fix_result;
          state_d  = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      bmag_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  op_i = 3'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        ready_o, busy_o, done_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .kill_i   (kill_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain 64-bit integer arithmetic plus the M-extension special cases
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (md_op_e'(op))
      MD_MUL:    begin sp = sa * sb; p = sp; return p[31:0]; end
      MD_MULH:   begin sp = sa * sb; p = sp; return p[63:32]; end
      MD_MULHSU: begin sp = sa * longint'(ub); p = sp; return p[63:32]; end
      MD_MULHU:  begin up = ua * ub; p = up; return p[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; p = sp; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; p = up; return p[31:0];
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; p = sp; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; p = up; return p[31:0];
      end
    endcase
  endfunction

  // One operation: accept at edge 0, scramble inputs, watch 40 edges for the done pulse
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    logic [31:0] got;
    int done_edge;
    int done_cnt;
    exp = ref_model(op, a, b);
    got = '0;
    done_edge = -1;
    done_cnt = 0;
    @(negedge clk_i);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    check({tag, "_ready"}, 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk_i); #1;
      if (e == 1) check({tag, "_busy"}, {62'b0, busy_o, ready_o}, 64'd2);
      if (done_o) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          got = result_o;
        end
      end
    end
    check({tag, "_latency"}, 64'(done_edge), 64'd33);
    check({tag, "_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_result"}, 64'(got), 64'(exp));
    check({tag, "_hold"}, 64'(result_o), 64'(exp));
  endtask

  initial begin
    int dcnt;
    int d1, d2;
    logic [31:0] r1, r2, rexp, ra, rb;
    logic [2:0]  rop;

    repeat (2) @(posedge clk_i);
    #1;
    check("reset_outputs", {ready_o, busy_o, done_o, result_o}, {3'b100, 32'h0});
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed vectors
    run_op("mul_7x-3", MD_MUL, 32'd7, 32'hFFFF_FFFD);
    run_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu_ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ff", MD_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mul_ff_const", 64'(result_o), 64'h1);
    run_op("div_-7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_-7_2_const", 64'(result_o), 64'hFFFF_FFFD);
    run_op("rem_-7_2", MD_REM, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_-7_2", MD_DIVU, 32'hFFFF_FFF9, 32'd2);
    run_op("remu_-7_2", MD_REMU, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", MD_DIVU, 32'd5, 32'd0);
    run_op("rem_by0", MD_REM, 32'd5, 32'd0);
    run_op("div_neg_by0", MD_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", 64'(result_o), 64'h8000_0000);
    run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized ops with a bias toward the corner operands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: rb = {{28{rb[31]}}, rb[3:0]};
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    // Kill mid-divide with start held throughout; result must clear and nothing completes
    run_op("pre_kill", MD_DIVU, 32'd100, 32'd7);
    @(negedge clk_i);
    op_i = MD_DIV; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk_i); #1;
    end
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    start_i = 1'b0;
    check("kill_outputs", {ready_o, busy_o, done_o, result_o}, {3'b100, 32'h0});
    dcnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk_i); #1;
      if (done_o) dcnt++;
    end
    check("kill_no_done", 64'(dcnt), 64'd0);
    run_op("post_kill_mul", MD_MUL, 32'd3, 32'd4);

    // Kill and start together while idle: kill wins
    @(negedge clk_i);
    op_i = MD_MUL; a_i = 32'd5; b_i = 32'd5; start_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; kill_i = 1'b0;
    check("kill_start_idle", {ready_o, busy_o, result_o}, {2'b10, 32'h0});

    // Reset mid-multiply
    run_op("pre_rst", MD_MUL, 32'd3, 32'd4);
    @(negedge clk_i);
    op_i = MD_MUL; a_i = 32'h1234; b_i = 32'h55; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst_outputs", {ready_o, busy_o, done_o, result_o}, {3'b100, 32'h0});
    dcnt = 0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk_i); #1;
      if (done_o) dcnt++;
    end
    check("rst_no_done", 64'(dcnt), 64'd0);
    run_op("post_rst", MD_MULH, $urandom, $urandom);

    // Back-to-back with start held: second op accepted on the first idle cycle after done
    ra = $urandom; rb = $urandom;
    rexp = ref_model(MD_REMU, ra, rb);
    d1 = -1; d2 = -1; dcnt = 0; r1 = '0; r2 = '0;
    @(negedge clk_i);
    op_i = MD_REMU; a_i = ra; b_i = rb; start_i = 1'b1;
    @(posedge clk_i); #1;
    for (int e = 1; e <= 75; e++) begin
      @(posedge clk_i); #1;
      if (e == 35) start_i = 1'b0;
      if (done_o) begin
        dcnt++;
        if (d1 < 0) begin d1 = e; r1 = result_o; end
        else if (d2 < 0) begin d2 = e; r2 = result_o; end
      end
    end
    check("b2b_pulses", 64'(dcnt), 64'd2);
    check("b2b_first_edge", 64'(d1), 64'd33);
    check("b2b_second_edge", 64'(d2), 64'd68);
    check("b2b_first_res", 64'(r1), 64'(rexp));
    check("b2b_second_res", 64'(r2), 64'(rexp));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL be parametrised by XLEN, default 32, giving the operand and result width in bits (legal values: 8..64, even).
REQ-002 clk_i  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 start_i  input  1  request; accepted only on an edge where ready_o=1 and kill_i=0.
REQ-005 kill_i  input  1  pipeline flush; aborts any operation in flight.
REQ-006 op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a_i  input  XLEN  operand rs1 (multiplicand / dividend).
REQ-008 b_i  input  XLEN  operand rs2 (multiplier / divisor).
REQ-009 ready_o  output  1  high only in IDLE.
REQ-010 busy_o  output  1  high in CALC and FIX.
REQ-011 done_o  output  1  single-cycle completion pulse, high only in DONE.
REQ-012 result_o  output  XLEN  registered result; holds its value until the next completion, kill or reset.

Function
REQ-013 The FSM SHALL have exactly four states, IDLE, CALC, FIX and DONE, and SHALL transition IDLE->CALC on acceptance, CALC->FIX after XLEN iterations, FIX->DONE, and DONE->IDLE unconditionally.
REQ-014 On acceptance, op_i, a_i and b_i SHALL be captured; later input changes SHALL NOT affect the operation in flight.
REQ-015 Latency SHALL be fixed for every op and operand value: with the accepting edge numbered 0, done_o SHALL be high between edges XLEN+1 and XLEN+2.
REQ-016 CALC SHALL perform one radix-2 iteration per cycle, with a counter running 0..XLEN-1: shift-add for multiplies and restoring shift-subtract for divides, both on operand magnitudes.
REQ-017 Multiplication SHALL form the 2*XLEN-bit product: MUL returns the low half; MULH, MULHSU and MULHU return the high half, with signed*signed, signed*unsigned and unsigned*unsigned operand treatment respectively.
REQ-018 FIX SHALL apply sign correction and load result_o: quotient negated when the operand signs differ (signed ops only); remainder takes the sign of the dividend.
REQ-019 Signed division SHALL round the quotient toward zero.
REQ-020 Divide by zero SHALL give quotient all-ones (DIV and DIVU) and remainder equal to a_i (REM and REMU), with unchanged latency.
REQ-021 Signed overflow (a_i = -2^(XLEN-1), b_i = -1) SHALL give DIV = a_i and REM = 0, with unchanged latency.
REQ-022 start_i while ready_o=0 SHALL be ignored; it SHALL NOT be queued.
REQ-023 kill_i=1 in any state SHALL force IDLE on the next edge; done_o SHALL stay low and result_o SHALL be cleared to 0.
REQ-024 If kill_i and start_i are both high in IDLE, kill SHALL win and the request SHALL be dropped.
REQ-025 A request SHALL be accepted in the first IDLE cycle after DONE; back-to-back throughput is therefore one op per XLEN+3 cycles.

Reset
REQ-026 While rst_i=1, the block SHALL enter IDLE on the clock edge, with ready_o=1, busy_o=0, done_o=0, result_o=0, the iteration counter at 0 and all operand registers at 0.
REQ-027 rst_i SHALL take priority over kill_i and start_i, including mid-operation; no done_o pulse SHALL follow a reset.

Structure
REQ-028 The op_i funct3 codes, the FSM state encoding and the XLEN default SHALL live in the shared CPU package, alongside the existing opcode and ALU-control constants.
REQ-029 The block SHALL be a single module with no sub-module; the iteration datapath and the FSM SHALL be inline.
REQ-030 The block SHALL be instantiable next to the ALU, and the datapath SHALL treat ready_o=0 as a pipeline stall condition.

Verification (XLEN=32)
REQ-031 MUL a=7, b=0xFFFFFFFD, start accepted at edge 0 -> done_o high between edges 33 and 34, result 0xFFFFFFEB.
REQ-032 a=b=0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF, MUL 0x00000001.
REQ-033 a=0xFFFFFFF9 (-7), b=2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF, DIVU 0x7FFFFFFC, REMU 0x00000001.
REQ-034 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; all complete at edge 33.
REQ-035 kill_i pulsed at edge 10 of a DIV, plus start_i held during busy -> no done_o, ready_o=1 after edge 10, result_o=0, then a new MUL 3*4 is accepted and returns 12.
REQ-036 rst_i asserted at edge 20 of a MUL -> all outputs at reset values after that edge, no later done_o, and the next start completes normally.
